// File: rtl/verify_pkg.sv
// Shared definitions for the player verification controller.
//   state_t     : FSM state encoding
//   fail_code_t : result code reported alongside the fail pulse
//   TAG_*       : memory-word record tags (word bits [10:8])
//   CNT_W       : width of the shared wait/latency counter (covers TIMEOUT up to 255)
package verify_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_AMT = 3'd1,
    S_GET_KEY = 3'd2,
    S_RD_AMT  = 3'd3,
    S_CHK_AMT = 3'd4,
    S_RD_KEY  = 3'd5,
    S_CHK_KEY = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_AMOUNT  = 2'b01,
    FC_KEY     = 2'b10,
    FC_TIMEOUT = 2'b11
  } fail_code_t;

  localparam logic [2:0] TAG_MONEY = 3'b001;
  localparam logic [2:0] TAG_KEY   = 3'b010;

  localparam int CNT_W = 8;

endpackage

// File: rtl/verify_control.sv
// Player verification controller.
// Collects an amount and a key from the user (each confirmed with go), then
// reads the player's money record and key record from memory and lets the
// datapath compare them. Reports a one-cycle pass or fail pulse with a code.
//
// Ports:
//   clock, resetn         : clock and asynchronous active-low reset
//   start, player_id      : begin verification of player_id (accepted in IDLE only)
//   go                    : user confirms the value on the datapath input bus
//   done_step, mem_tag    : datapath compare result and tag of the current memory word
//   load_amount, load_key : datapath register load strobes (combinational on go)
//   mem_addr              : {player,0} = money record, {player,1} = key record
//   busy                  : high in every state except IDLE
//   pass, fail, fail_code : one-cycle result in DONE; fail_code is 00 whenever fail=0
module verify_control
  import verify_pkg::*;
#(
  parameter  int PLAYER_W = 2,
  parameter  int MEM_LAT  = 1,
  parameter  int TIMEOUT  = 255,
  localparam int ADDR_W   = PLAYER_W + 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [PLAYER_W-1:0] player_id,
  input  logic                go,
  input  logic                done_step,
  input  logic [2:0]          mem_tag,
  output logic                load_amount,
  output logic                load_key,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic [1:0]          fail_code
);

  state_t              state, state_next;
  fail_code_t          code_q, code_next;
  logic [PLAYER_W-1:0] player_q;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                wait_expired;
  logic                lat_done;

  // One counter serves both the user-input timeout and the memory latency;
  // it restarts from zero on every state change.
  assign wait_expired = (cnt == CNT_W'(TIMEOUT - 1));
  assign lat_done     = (cnt == CNT_W'(MEM_LAT - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; only combinational blocks use blocking assignments.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      code_q   <= FC_NONE;
      player_q <= '0;
      cnt      <= '0;
    end else begin
      state  <= state_next;
      code_q <= code_next;
      cnt    <= cnt_next;
      if (state == S_IDLE && start) player_q <= player_id;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    code_next   = code_q;
    load_amount = 1'b0;
    load_key    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_GET_AMT;
          code_next  = FC_NONE;
        end
      end
      S_GET_AMT: begin
        // go wins over an expiry in the same cycle
        if (go) begin
          load_amount = 1'b1;
          state_next  = S_GET_KEY;
        end else if (wait_expired) begin
          state_next = S_DONE;
          code_next  = FC_TIMEOUT;
        end
      end
      S_GET_KEY: begin
        if (go) begin
          load_key   = 1'b1;
          state_next = S_RD_AMT;
        end else if (wait_expired) begin
          state_next = S_DONE;
          code_next  = FC_TIMEOUT;
        end
      end
      S_RD_AMT: begin
        if (lat_done) state_next = S_CHK_AMT;
      end
      S_CHK_AMT: begin
        if (done_step && mem_tag == TAG_MONEY) begin
          state_next = S_RD_KEY;
        end else begin
          state_next = S_DONE;
          code_next  = FC_AMOUNT;
        end
      end
      S_RD_KEY: begin
        if (lat_done) state_next = S_CHK_KEY;
      end
      S_CHK_KEY: begin
        state_next = S_DONE;
        code_next  = (done_step && mem_tag == TAG_KEY) ? FC_NONE : FC_KEY;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    cnt_next = (state_next != state || state == S_IDLE) ? '0 : cnt + 1'b1;
  end

  always_comb begin
    mem_addr = '0;
    unique case (state)
      S_RD_AMT, S_CHK_AMT: mem_addr = {player_q, 1'b0};
      S_RD_KEY, S_CHK_KEY: mem_addr = {player_q, 1'b1};
      default:             mem_addr = '0;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign pass      = (state == S_DONE) && (code_q == FC_NONE);
  assign fail      = (state == S_DONE) && (code_q != FC_NONE);
  assign fail_code = fail ? code_q : FC_NONE;

endmodule

// File: tb/tb_verify_control.sv
// Self-checking bench for verify_control (PLAYER_W=2, MEM_LAT=1, TIMEOUT=4).
// A small memory model answers mem_addr with tag/done values; each vector
// loads that memory, drives start and the go schedule, and the expected
// result is queued when start is driven and compared when pass/fail appears.
module tb_verify_control;

  localparam int PLAYER_W = 2;
  localparam int MEM_LAT  = 1;
  localparam int TO       = 4;
  localparam int NOGO     = 99;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic                start = 1'b0;
  logic [PLAYER_W-1:0] player_id = '0;
  logic                go = 1'b0;
  logic                done_step;
  logic [2:0]          mem_tag;
  logic                load_amount, load_key;
  logic [PLAYER_W:0]   mem_addr;
  logic                busy, pass, fail;
  logic [1:0]          fail_code;

  logic [2:0] tag_mem  [8];
  logic       done_mem [8];

  assign mem_tag   = tag_mem[mem_addr];
  assign done_step = done_mem[mem_addr];

  verify_control #(
    .PLAYER_W(PLAYER_W),
    .MEM_LAT (MEM_LAT),
    .TIMEOUT (TO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .player_id  (player_id),
    .go         (go),
    .done_step  (done_step),
    .mem_tag    (mem_tag),
    .load_amount(load_amount),
    .load_key   (load_key),
    .mem_addr   (mem_addr),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         player;
    int         da;        // idle GET_AMT cycles before go (NOGO = never)
    int         dk;        // idle GET_KEY cycles before go (NOGO = never)
    bit         done_amt;
    logic [2:0] tag_amt;
    bit         done_key;
    logic [2:0] tag_key;
    bit         noise;     // hold start/alt player and stray go while busy
  } vec_t;

  typedef struct {
    bit         pass;
    logic [1:0] code;
    int         lat;       // clock edges from start to visible result
    bit         saw_key;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   tests = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    bit amt_ok, key_ok;
    amt_ok = v.done_amt && (v.tag_amt == 3'b001);
    key_ok = v.done_key && (v.tag_key == 3'b010);
    e.saw_key = 1'b0;
    e.pass    = 1'b0;
    if (v.da >= TO) begin
      e.code = 2'b11; e.lat = 1 + TO;
    end else if (v.dk >= TO) begin
      e.code = 2'b11; e.lat = 1 + (v.da + 1) + TO;
    end else if (!amt_ok) begin
      e.code = 2'b01; e.lat = v.da + v.dk + 5;
    end else if (!key_ok) begin
      e.code = 2'b10; e.lat = v.da + v.dk + 7; e.saw_key = 1'b1;
    end else begin
      e.code = 2'b00; e.lat = v.da + v.dk + 7; e.saw_key = 1'b1; e.pass = 1'b1;
    end
    return e;
  endfunction

  task automatic load_mem(input vec_t v);
    for (int a = 0; a < 8; a++) begin
      tag_mem[a]  = 3'b000;
      done_mem[a] = 1'b0;
    end
    tag_mem[v.player*2]    = v.tag_amt;
    done_mem[v.player*2]   = v.done_amt;
    tag_mem[v.player*2+1]  = v.tag_key;
    done_mem[v.player*2+1] = v.done_key;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, got;
    int   amt_a, key_a;
    bit   go_amt, go_key, seen, saw_key, busy_bad, code_bad, strobe_bad;
    amt_a = v.player * 2;
    key_a = amt_a + 1;
    load_mem(v);
    e = expect_of(v);
    @(negedge clock);
    start     = 1'b1;
    player_id = PLAYER_W'(v.player);
    sb.push_back(e);
    seen = 0; saw_key = 0; busy_bad = 0; code_bad = 0; strobe_bad = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clock);
      start     = v.noise;
      player_id = v.noise ? PLAYER_W'(v.player ^ 3) : PLAYER_W'(v.player);
      go_amt = (v.da < TO) && (c == v.da + 1);
      go_key = (v.da < TO) && (v.dk < TO) && (c == v.da + v.dk + 2);
      go = go_amt || go_key || (v.noise && c > v.da + v.dk + 2);
      #1;
      if (go_amt) check($sformatf("load_amount_v%0d", idx), {load_amount, load_key}, 2'b10);
      if (go_key) check($sformatf("load_key_v%0d", idx), {load_amount, load_key}, 2'b01);
      if (!go_amt && !go_key && (load_amount || load_key)) strobe_bad = 1;
      if (e.code != 2'b11 && c == v.da + v.dk + 3)
        check($sformatf("addr_amt_v%0d", idx), mem_addr, amt_a);
      if (e.code != 2'b11 && c == v.da + v.dk + 5)
        check($sformatf("addr_key_v%0d", idx), mem_addr, e.code == 2'b01 ? 0 : key_a);
      if (mem_addr == key_a) saw_key = 1;
      if (pass || fail) begin
        seen = 1;
        got = sb.pop_front();
        check($sformatf("pass_fail_v%0d", idx), {pass, fail}, got.pass ? 2'b10 : 2'b01);
        check($sformatf("fail_code_v%0d", idx), fail_code, got.code);
        check($sformatf("latency_v%0d", idx), c, got.lat);
        check($sformatf("key_visit_v%0d", idx), saw_key, got.saw_key);
      end else begin
        if (!busy) busy_bad = 1;
        if (fail_code != 2'b00) code_bad = 1;
      end
    end
    check($sformatf("result_seen_v%0d", idx), seen, 1);
    if (!seen && sb.size() > 0) void'(sb.pop_front());
    check($sformatf("busy_held_v%0d", idx), busy_bad, 0);
    check($sformatf("code_quiet_v%0d", idx), code_bad, 0);
    check($sformatf("stray_strobe_v%0d", idx), strobe_bad, 0);
    @(negedge clock);
    start = 1'b0;
    go    = 1'b0;
    #1;
    check($sformatf("idle_after_v%0d", idx), {busy, pass, fail, fail_code}, 5'b0);
  endtask

  function automatic logic [9:0] outs();
    return {busy, pass, fail, load_amount, load_key, fail_code, mem_addr};
  endfunction

  initial begin
    bit idle_bad;
    //          player da    dk    d_amt tag_amt d_key tag_key noise
    vecs[0] = '{2, 0,    0,    1, 3'b001, 1, 3'b010, 0};  // happy path
    vecs[1] = '{1, 2,    1,    0, 3'b001, 1, 3'b010, 0};  // amount compare fails
    vecs[2] = '{3, 0,    3,    1, 3'b010, 1, 3'b010, 0};  // wrong tag on amount word
    vecs[3] = '{0, 1,    0,    1, 3'b001, 1, 3'b001, 0};  // wrong tag on key word
    vecs[4] = '{2, 0,    2,    1, 3'b001, 0, 3'b010, 0};  // key compare fails
    vecs[5] = '{1, NOGO, NOGO, 1, 3'b001, 1, 3'b010, 0};  // timeout in GET_AMT
    vecs[6] = '{3, 3,    0,    1, 3'b001, 1, 3'b010, 0};  // go on the last allowed cycle
    vecs[7] = '{0, 1,    NOGO, 1, 3'b001, 1, 3'b010, 0};  // timeout in GET_KEY
    vecs[8] = '{1, 1,    0,    1, 3'b001, 1, 3'b010, 1};  // start/go noise while busy

    for (int a = 0; a < 8; a++) begin
      tag_mem[a]  = 3'b000;
      done_mem[a] = 1'b0;
    end

    // Reset state, then go in IDLE must do nothing.
    #2;
    check("outs_in_reset", outs(), 10'b0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check("outs_after_reset", outs(), 10'b0);
    idle_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      go = 1'b1;
      #1;
      if (outs() != 10'b0) idle_bad = 1;
    end
    @(negedge clock);
    go = 1'b0;
    #1;
    check("go_in_idle", {idle_bad, outs()}, 11'b0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset asserted while in RD_KEY clears everything at once.
    load_mem(vecs[0]);
    @(negedge clock);
    start = 1'b1; player_id = 2'd2;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      start = 1'b0;
      go    = (c == 1) || (c == 2);
    end
    #1;
    check("addr_before_reset", mem_addr, 3'd5);
    #1;
    resetn = 1'b0;
    #1;
    check("outs_async_reset", outs(), 10'b0);
    @(negedge clock);
    go = 1'b0;
    #1;
    check("outs_held_reset", outs(), 10'b0);
    resetn = 1'b1;
    run_vec(vecs[0], 9);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/verify_control.md
VERIFY_CONTROL -- requirements
Module: verify_control

Interface
REQ-001 SHALL have parameter PLAYER_W, default 2, player index width; ADDR_W = PLAYER_W+1 derived.
REQ-002 SHALL have parameter MEM_LAT, default 1, cycles from mem_addr change to valid memory word (range 1-7).
REQ-003 SHALL have parameter TIMEOUT, default 255, idle cycles allowed waiting for go (range 1-255).
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  request: begin verification for player_id.
REQ-007 SHALL have port player_id  in  PLAYER_W  player under verification; sampled on accepted start.
REQ-008 SHALL have port go  in  1  user confirms entered value on datapath input bus.
REQ-009 SHALL have port done_step  in  1  datapath check result for current memory word.
REQ-010 SHALL have port mem_tag  in  3  memory word bits [10:8]; 001 = money record, 010 = key record.
REQ-011 SHALL have ports load_amount / load_key  out  1 each  datapath register load strobes.
REQ-012 SHALL have port mem_addr  out  ADDR_W  memory read address.
REQ-013 SHALL have ports busy, pass, fail  out  1 each; fail_code  out  2  (00 none, 01 amount, 10 key, 11 timeout).

Function
REQ-014 SHALL implement states IDLE, GET_AMT, GET_KEY, RD_AMT, CHK_AMT, RD_KEY, CHK_KEY, DONE.
REQ-015 SHALL, in IDLE with start=1, latch player_id and enter GET_AMT next cycle; start outside IDLE ignored.
REQ-016 SHALL drive busy=1 in every state except IDLE.
REQ-017 SHALL assert load_amount combinationally iff state=GET_AMT and go=1, then enter GET_KEY.
REQ-018 SHALL assert load_key combinationally iff state=GET_KEY and go=1, then enter RD_AMT.
REQ-019 SHALL count cycles in GET_AMT/GET_KEY; counter cleared on state entry; at TIMEOUT cycles without go, enter DONE with fail_code=11.
REQ-020 SHALL give go priority over timeout expiry in the same cycle.
REQ-021 SHALL drive mem_addr={player,1'b0} in RD_AMT/CHK_AMT, {player,1'b1} in RD_KEY/CHK_KEY, 0 otherwise.
REQ-022 SHALL remain in RD_AMT/RD_KEY exactly MEM_LAT cycles, then enter CHK_AMT/CHK_KEY.
REQ-023 SHALL stay one cycle in CHK_AMT, sampling done_step and mem_tag: both done_step=1 and mem_tag=001 -> RD_KEY, else DONE with fail_code=01.
REQ-024 SHALL stay one cycle in CHK_KEY: done_step=1 and mem_tag=010 -> DONE with pass result, else DONE with fail_code=10.
REQ-025 SHALL, in DONE, pulse exactly one of pass or fail for one cycle, hold fail_code valid that cycle, then return to IDLE.
REQ-026 SHALL hold fail_code=00 whenever fail=0.
REQ-027 SHALL ignore go in IDLE, RD_*, CHK_* and DONE.

Reset
REQ-028 SHALL, on resetn=0 at any time including mid-sequence, immediately enter IDLE and clear counters and latched player.
REQ-029 SHALL hold busy, pass, fail, load_amount, load_key=0, fail_code=00, mem_addr=0 during reset.

Structure
REQ-030 SHALL place state encoding, fail_code values and tag constants (001, 010) in shared package verify_pkg.
REQ-031 SHALL be a single module with one FSM plus one shared wait/timeout counter; no sub-modules.

Verification
REQ-032 SHALL cover happy path: MEM_LAT=1, player_id=2, start, go twice, done_step=1 with tags 001 then 010 -> mem_addr 4 then 5, pass pulse 1 cycle, busy low next cycle.
REQ-033 SHALL cover amount failure: done_step=0 in CHK_AMT -> fail=1, fail_code=01, state never visits RD_KEY (mem_addr never 5).
REQ-034 SHALL cover tag mismatch: done_step=1, mem_tag=010 in CHK_AMT -> fail_code=01.
REQ-035 SHALL cover timeout: TIMEOUT=4, no go after start -> fail, fail_code=11 at 4th GET_AMT cycle; go coincident with 4th cycle -> load_amount, no fail.
REQ-036 SHALL cover reset mid-RD_KEY -> all outputs 0 asynchronously; new start afterward completes normally.
REQ-037 SHALL cover start while busy and go in IDLE -> no effect on state or outputs.
